// File: rtl/rom_arb_pkg.sv
// Shared types and widths for the firmware ROM access arbiter.
// Slot states, grant owners and the ROM/checksum geometry live here.
package rom_arb_pkg;

   localparam int ROM_ADDR_W = 15;
   localparam int ROM_DATA_W = 8;
   localparam int SUM_W      = 16;

   typedef enum logic [1:0] {IDLE, READ, CAPT, ACK} state_t;
   typedef enum logic [1:0] {GNT_CPU, GNT_HOST, GNT_SCAN} grant_t;

endpackage

// File: rtl/rom_access_arbiter_if.sv
// Request/acknowledge bundle for the CPU bus port and the host readback port.
// The requesters use the master modport; the arbiter uses the slave modport.
interface rom_access_arbiter_if
   import rom_arb_pkg::*;
#(
   parameter int ADDR_W = ROM_ADDR_W,
   parameter int DATA_W = ROM_DATA_W
);

   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_data;

   logic              host_req;
   logic [ADDR_W-1:0] host_addr;
   logic              host_ack;
   logic [DATA_W-1:0] host_data;

   modport master (
      output cpu_req, cpu_addr, host_req, host_addr,
      input  cpu_ack, cpu_data, host_ack, host_data
   );

   modport slave (
      input  cpu_req, cpu_addr, host_req, host_addr,
      output cpu_ack, cpu_data, host_ack, host_data
   );

endinterface

// File: rtl/rom_sum_scanner.sv
// Background firmware checksum scanner: walks the whole ROM once after reset,
// accumulating every byte modulo 2^SUM_W, then raises done and stops.
module rom_sum_scanner
   import rom_arb_pkg::*;
#(
   parameter int ADDR_W = ROM_ADDR_W,
   parameter int DATA_W = ROM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              capture,
   input  logic [DATA_W-1:0] data,
   output logic [ADDR_W-1:0] addr,
   output logic              active,
   output logic [SUM_W-1:0]  sum,
   output logic              done
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
         sum  <= '0;
         done <= 1'b0;
      end else if (capture && !done) begin
         sum  <= sum + SUM_W'(data);
         addr <= addr + 1'b1;
         if (&addr) done <= 1'b1;
      end
   end

   assign active = !done;

endmodule

// File: rtl/rom_access_arbiter.sv
// Fixed 4-slot sequencer sharing the firmware ROM between CPU and host ports.
// Optional background checksum scanner is built when ROM_SUM_EN is defined.
module rom_access_arbiter
   import rom_arb_pkg::*;
#(
   parameter int ADDR_W        = ROM_ADDR_W,
   parameter int DATA_W        = ROM_DATA_W,
   parameter int HOST_MAX_WAIT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rom_access_arbiter_if.slave  bus,
   output logic [ADDR_W-1:0]    rom_addr,
   output logic                 rom_oe,
   input  logic [DATA_W-1:0]    rom_data,
   output logic                 busy,
   output logic [SUM_W-1:0]     sum_out,
   output logic                 sum_valid
);

   localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

   state_t            state;
   grant_t            grant;
   logic [3:0]        wait_cnt;
   logic              host_wins;
   logic              scan_req;
   logic [ADDR_W-1:0] scan_addr;

   // Host is forced through once the CPU has won MAX_WAIT contested slots in a row.
   assign host_wins = bus.host_req && (!bus.cpu_req || (wait_cnt == MAX_WAIT));

`ifdef ROM_SUM_EN
   logic scan_capture;

   assign scan_capture = (state == CAPT) && (grant == GNT_SCAN);

   rom_sum_scanner #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_scanner (
      .clk     (clk),
      .rst_n   (rst_n),
      .capture (scan_capture),
      .data    (rom_data),
      .addr    (scan_addr),
      .active  (scan_req),
      .sum     (sum_out),
      .done    (sum_valid)
   );
`else
   assign scan_req  = 1'b0;
   assign scan_addr = '0;
   assign sum_out   = '0;
   assign sum_valid = 1'b0;
`endif

   // NOTE: every register here is updated with <= so all flops see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant        <= GNT_CPU;
         wait_cnt     <= '0;
         rom_addr     <= '0;
         rom_oe       <= 1'b0;
         bus.cpu_ack  <= 1'b0;
         bus.host_ack <= 1'b0;
         bus.cpu_data <= '0;
         bus.host_data <= '0;
      end else begin
         bus.cpu_ack  <= 1'b0;
         bus.host_ack <= 1'b0;
         case (state)
            IDLE: begin
               rom_oe <= 1'b0;
               if (host_wins) begin
                  grant    <= GNT_HOST;
                  rom_addr <= bus.host_addr;
                  rom_oe   <= 1'b1;
                  wait_cnt <= '0;
                  state    <= READ;
               end else if (bus.cpu_req) begin
                  grant    <= GNT_CPU;
                  rom_addr <= bus.cpu_addr;
                  rom_oe   <= 1'b1;
                  wait_cnt <= bus.host_req ? wait_cnt + 4'd1 : 4'd0;
                  state    <= READ;
               end else begin
                  wait_cnt <= '0;
                  if (scan_req) begin
                     grant    <= GNT_SCAN;
                     rom_addr <= scan_addr;
                     rom_oe   <= 1'b1;
                     state    <= READ;
                  end
               end
            end
            READ: begin
               rom_oe <= 1'b0;
               state  <= CAPT;
            end
            CAPT: begin
               case (grant)
                  GNT_CPU: begin
                     bus.cpu_data <= rom_data;
                     bus.cpu_ack  <= 1'b1;
                  end
                  GNT_HOST: begin
                     bus.host_data <= rom_data;
                     bus.host_ack  <= 1'b1;
                  end
                  default: ;
               endcase
               state <= ACK;
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule
